// File: rtl/arbiter_rr_n_if.sv
// Request/grant/select bundle between the round-robin arbiter and its masters.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface arbiter_rr_n_if #(
  parameter int unsigned N = 3
) ();
  localparam int unsigned IDX_W = (N <= 2) ? 1 : $clog2(N);

  logic [N-1:0]     req;
  logic             finish;
  logic [N-1:0]     gnt;
  logic [N-1:0]     sel;
  logic [IDX_W-1:0] owner;
  logic             busy;
  logic             hold_to;
  logic [IDX_W-1:0] to_owner;

  modport slave (
    input  req, finish,
    output gnt, sel, owner, busy, hold_to, to_owner
  );

  modport master (
    output req, finish,
    input  gnt, sel, owner, busy, hold_to, to_owner
  );
endinterface

// File: rtl/arbiter_rr_n.sv
// N-way round-robin bus arbiter with back-to-back handover and a hold watchdog.
// gnt is combinational; sel/owner/busy/hold_to/to_owner are registered.
module arbiter_rr_n #(
  parameter int unsigned N        = 3,
  parameter int unsigned MAX_HOLD = 0
) (
  input  logic          clk,
  input  logic          rst,
  arbiter_rr_n_if.slave bus
);
  localparam int unsigned IDX_W   = (N <= 2) ? 1 : $clog2(N);
  localparam int unsigned CNT_W   = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
  localparam int unsigned FIRE_AT = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  // Two-hot-free encoding leaves 2'b00/2'b11 as detectable illegal states.
  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    GRANT = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] to_owner_q, to_owner_d;
  logic [N-1:0]     sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             hold_to_q, hold_to_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic             wd_fire_c;
  logic             release_c;
  logic             found_c;
  logic [IDX_W-1:0] base_c;
  logic [IDX_W-1:0] win_c;
  logic [N-1:0]     gnt_c;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] b,
                                                 input int unsigned     k);
    return IDX_W'((32'(b) + k) % N);
  endfunction

  // Release on finish, or on watchdog expiry when finish is absent.
  always_comb begin
    wd_fire_c = (MAX_HOLD != 0) && (state_q == GRANT) &&
                (hold_cnt_q == CNT_W'(FIRE_AT)) && !bus.finish;
    release_c = (state_q == GRANT) && (bus.finish || wd_fire_c);
    base_c    = release_c ? wrap_add(owner_q, 1) : ptr_q;
  end

  // First requester at or after base, wrapping at N-1.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found_c && bus.req[wrap_add(base_c, k)]) begin
        found_c = 1'b1;
        win_c   = wrap_add(base_c, k);
      end
    end
  end

  always_comb begin
    gnt_c = '0;
    if (found_c && ((state_q == IDLE) || release_c)) begin
      gnt_c = N'(1) << win_c;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    to_owner_d = to_owner_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    hold_to_d  = 1'b0;
    hold_cnt_d = '0;

    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d = GRANT;
          sel_d   = gnt_c;
          owner_d = win_c;
          busy_d  = 1'b1;
        end else begin
          sel_d  = '0;
          busy_d = 1'b0;
        end
      end
      GRANT: begin
        if (release_c) begin
          ptr_d = base_c;
          if (wd_fire_c) begin
            hold_to_d  = 1'b1;
            to_owner_d = owner_q;
          end
          if (found_c) begin
            sel_d   = gnt_c;
            owner_d = win_c;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            sel_d   = '0;
            busy_d  = 1'b0;
          end
        end else begin
          hold_cnt_d = (hold_cnt_q == CNT_SAT) ? hold_cnt_q
                                               : hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      to_owner_q <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      hold_to_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      to_owner_q <= to_owner_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      hold_to_q  <= hold_to_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.gnt      = gnt_c;
  assign bus.sel      = sel_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = busy_q;
  assign bus.hold_to  = hold_to_q;
  assign bus.to_owner = to_owner_q;
endmodule

// File: tb/tb_arbiter_rr_n.sv
// Directed bench for arbiter_rr_n: three instances (N=3 no watchdog, N=3 MAX_HOLD=8, N=5).
// Inputs change on the falling edge; registered outputs are read there, gnt 1 ns later.
module tb_arbiter_rr_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  arbiter_rr_n_if #(.N(3)) bus_a ();
  arbiter_rr_n_if #(.N(3)) bus_b ();
  arbiter_rr_n_if #(.N(5)) bus_c ();

  arbiter_rr_n #(.N(3), .MAX_HOLD(0)) u_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
  arbiter_rr_n #(.N(3), .MAX_HOLD(8)) u_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));
  arbiter_rr_n #(.N(5), .MAX_HOLD(0)) u_c (.clk(clk), .rst(rst_c), .bus(bus_c.slave));

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int unsigned ord [5] = '{0, 1, 2, 0, 0};

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    bus_a.req = '0; bus_a.finish = 1'b0;
    bus_b.req = '0; bus_b.finish = 1'b0;
    bus_c.req = '0; bus_c.finish = 1'b0;

    // Reset values
    @(negedge clk);
    check_eq("rst_sel",      32'(bus_a.sel),      32'h0);
    check_eq("rst_busy",     32'(bus_a.busy),     32'h0);
    check_eq("rst_owner",    32'(bus_a.owner),    32'h0);
    check_eq("rst_hold_to",  32'(bus_a.hold_to),  32'h0);
    check_eq("rst_to_owner", 32'(bus_a.to_owner), 32'h0);
    check_eq("rst_gnt",      32'(bus_a.gnt),      32'h0);
    check_eq("rst_sel_c",    32'(bus_c.sel),      32'h0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // 1: all request, finish every 4 cycles -> order 0,1,2,0
    @(negedge clk);
    bus_a.req = 3'b111;
    #1 check_eq("t1_gnt_first", 32'(bus_a.gnt), 32'h1);
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        bus_a.finish = 1'b0;
        check_eq("t1_sel",   32'(bus_a.sel),   32'(1) << ord[i]);
        check_eq("t1_owner", 32'(bus_a.owner), ord[i]);
        check_eq("t1_busy",  32'(bus_a.busy),  32'h1);
        if (c == 3) begin
          bus_a.finish = 1'b1;
          if (i < 3) begin
            #1 check_eq("t1_gnt_next", 32'(bus_a.gnt), 32'(1) << ord[i+1]);
          end else begin
            bus_a.req = '0;
            #1 check_eq("t1_gnt_none", 32'(bus_a.gnt), 32'h0);
          end
        end else begin
          #1 check_eq("t1_gnt_hold", 32'(bus_a.gnt), 32'h0);
        end
      end
    end
    @(negedge clk);
    bus_a.finish = 1'b0;
    check_eq("t1_idle_busy", 32'(bus_a.busy), 32'h0);
    check_eq("t1_idle_sel",  32'(bus_a.sel),  32'h0);

    // 2: lone request from IDLE, drop to IDLE, pointer wraps to 0
    bus_a.req = 3'b100;
    #1 check_eq("t2_gnt", 32'(bus_a.gnt), 32'h4);
    @(negedge clk);
    check_eq("t2_sel",   32'(bus_a.sel),   32'h4);
    check_eq("t2_owner", 32'(bus_a.owner), 32'h2);
    check_eq("t2_busy",  32'(bus_a.busy),  32'h1);
    bus_a.req = '0;
    bus_a.finish = 1'b1;
    #1 check_eq("t2_gnt_none", 32'(bus_a.gnt), 32'h0);
    @(negedge clk);
    bus_a.finish = 1'b0;
    check_eq("t2_busy_off", 32'(bus_a.busy), 32'h0);
    check_eq("t2_sel_off",  32'(bus_a.sel),  32'h0);
    bus_a.req = 3'b011;
    #1 check_eq("t2_gnt_wrap", 32'(bus_a.gnt), 32'h1);
    @(negedge clk);
    check_eq("t2_owner0", 32'(bus_a.owner), 32'h0);

    // 3: sole requester re-granted back-to-back
    bus_a.req = 3'b010;
    bus_a.finish = 1'b1;
    #1 check_eq("t3_gnt1", 32'(bus_a.gnt), 32'h2);
    @(negedge clk);
    check_eq("t3_owner1", 32'(bus_a.owner), 32'h1);
    #1 check_eq("t3_regrant", 32'(bus_a.gnt), 32'h2);
    @(negedge clk);
    check_eq("t3_busy", 32'(bus_a.busy),  32'h1);
    check_eq("t3_own",  32'(bus_a.owner), 32'h1);
    check_eq("t3_sel",  32'(bus_a.sel),   32'h2);
    bus_a.req = '0;
    @(negedge clk);
    bus_a.finish = 1'b0;
    check_eq("t3_idle", 32'(bus_a.busy), 32'h0);

    // 4: stuck owner 0; B's watchdog releases after 8 held cycles, A holds on
    bus_a.req = 3'b001;
    bus_b.req = 3'b001;
    #1;
    check_eq("t4_gnt_a", 32'(bus_a.gnt), 32'h1);
    check_eq("t4_gnt_b", 32'(bus_b.gnt), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus_a.req = 3'b011;
        bus_b.req = 3'b011;
      end
      #1;
      check_eq("t4_gnt_a_hold", 32'(bus_a.gnt), 32'h0);
      if (k < 8) begin
        check_eq("t4_gnt_b_hold", 32'(bus_b.gnt),     32'h0);
        check_eq("t4_hold_to_lo", 32'(bus_b.hold_to), 32'h0);
      end else begin
        check_eq("t4_wd_gnt", 32'(bus_b.gnt), 32'h2);
      end
    end
    @(negedge clk);
    check_eq("t4_hold_to",  32'(bus_b.hold_to),  32'h1);
    check_eq("t4_to_owner", 32'(bus_b.to_owner), 32'h0);
    check_eq("t4_owner_b",  32'(bus_b.owner),    32'h1);
    check_eq("t4_sel_b",    32'(bus_b.sel),      32'h2);
    @(negedge clk);
    check_eq("t4_hold_to_pulse", 32'(bus_b.hold_to), 32'h0);
    check_eq("t4_a_busy",        32'(bus_a.busy),    32'h1);
    check_eq("t4_a_owner",       32'(bus_a.owner),   32'h0);
    check_eq("t4_a_hold_to",     32'(bus_a.hold_to), 32'h0);
    bus_a.req = '0; bus_a.finish = 1'b1;
    bus_b.req = '0; bus_b.finish = 1'b1;
    @(negedge clk);
    bus_a.finish = 1'b0;
    bus_b.finish = 1'b0;
    check_eq("t4_a_idle", 32'(bus_a.busy), 32'h0);
    check_eq("t4_b_idle", 32'(bus_b.busy), 32'h0);

    // 5: finish lands in the watchdog cycle -> ordinary handover, no hold_to
    bus_b.req = 3'b001;
    #1 check_eq("t5_gnt0", 32'(bus_b.gnt), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus_b.req = 3'b011;
      if (k == 8) bus_b.finish = 1'b1;
      #1;
      if (k < 8) check_eq("t5_gnt_hold", 32'(bus_b.gnt), 32'h0);
      else       check_eq("t5_gnt_fin",  32'(bus_b.gnt), 32'h2);
    end
    @(negedge clk);
    bus_b.finish = 1'b0;
    check_eq("t5_hold_to", 32'(bus_b.hold_to), 32'h0);
    check_eq("t5_owner",   32'(bus_b.owner),   32'h1);
    check_eq("t5_busy",    32'(bus_b.busy),    32'h1);
    bus_b.req = '0;
    bus_b.finish = 1'b1;
    @(negedge clk);
    bus_b.finish = 1'b0;

    // 6: N=5, asynchronous reset while owner=3, then re-arbitrate from ptr 0
    bus_c.req = 5'b01000;
    #1 check_eq("t6_gnt", 32'(bus_c.gnt), 32'h08);
    @(negedge clk);
    check_eq("t6_owner", 32'(bus_c.owner), 32'h3);
    check_eq("t6_busy",  32'(bus_c.busy),  32'h1);
    #2 rst_c = 1'b1;
    bus_c.req = '0;
    #1;
    check_eq("t6_rst_sel",   32'(bus_c.sel),   32'h0);
    check_eq("t6_rst_busy",  32'(bus_c.busy),  32'h0);
    check_eq("t6_rst_owner", 32'(bus_c.owner), 32'h0);
    @(negedge clk);
    rst_c = 1'b0;
    bus_c.req = 5'b11000;
    #1 check_eq("t6_gnt_after", 32'(bus_c.gnt), 32'h08);
    @(negedge clk);
    check_eq("t6_owner_after", 32'(bus_c.owner), 32'h3);
    check_eq("t6_sel_after",   32'(bus_c.sel),   32'h08);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
